// File: rtl/neuron_sched.sv
// neuron_sched: round-robin synapse event arbiter, 4-deep event queue,
// dendrite pulse sequencer with settle/refractory timing and weight registers.
module neuron_sched #(
    parameter int SETTLE_CYC  = 4,
    parameter int REFRACT_CYC = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [2:0] syn_req,
    output logic [2:0] syn_gnt,
    input  logic       cfg_we,
    input  logic [1:0] cfg_sel,
    input  logic [3:0] cfg_wdata,
    input  logic       en,
    input  logic       out_pulse,
    output logic       DE1,
    output logic       DE2,
    output logic       DE3,
    output logic [3:0] W1,
    output logic [3:0] W2,
    output logic [3:0] W3,
    output logic       busy,
    output logic       refractory,
    output logic [7:0] spike_cnt,
    output logic [7:0] drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = 8;
    localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] REF_LD = TW'(REFRACT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_REFR
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [1:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [2:0]    de_q, de_d;
    logic [3:0]    w_q [3];
    logic [3:0]    w_d [3];
    logic          op_q;
    logic [7:0]    spk_q, spk_d, drp_q, drp_d;

    logic       full, can_grant, push, pop, flush;
    logic [1:0] gnt_idx, head;
    logic [2:0] gnt, cand;

    // Depth is a power of two, so the extra count bit alone marks full.
    assign full      = cnt_q[AW];
    assign can_grant = Rst_n && !full && (state_q != S_REFR);
    assign head      = mem_q[rp_q];

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        push    = 1'b0;
        cand    = '0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (can_grant && !push && syn_req[cand[1:0]]) begin
                push    = 1'b1;
                gnt_idx = cand[1:0];
            end
        end
        if (push) gnt[gnt_idx] = 1'b1;
        rr_d = rr_q;
        if (push) rr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        de_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (out_pulse) begin
                    state_d = S_REFR;
                    tmr_d   = REF_LD;
                end else if (en && cnt_q != '0) begin
                    state_d    = S_ISSUE;
                    pop        = 1'b1;
                    de_d[head] = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
                tmr_d   = SET_LD;
            end
            S_SETTLE: begin
                if (out_pulse) begin
                    state_d = S_REFR;
                    tmr_d   = REF_LD;
                end else if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_REFR: begin
                if (tmr_q == '0) state_d = S_IDLE;
                else tmr_d = tmr_q - TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign flush = (state_d == S_REFR) && (state_q != S_REFR);

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wp_q] = gnt_idx;
                wp_d        = wp_q + AW'(1);
            end
            if (pop) rp_d = rp_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_comb begin
        w_d = w_q;
        if (cfg_we && cfg_sel != 2'd3) w_d[cfg_sel] = cfg_wdata;
        spk_d = spk_q;
        if (out_pulse && !op_q && spk_q != 8'hFF) spk_d = spk_q + 8'd1;
        drp_d = drp_q;
        if (state_q == S_REFR && |syn_req && drp_q != 8'hFF)
            drp_d = drp_q + 8'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rr_q    <= '0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            de_q    <= '0;
            w_q     <= '{default: '0};
            op_q    <= 1'b0;
            spk_q   <= '0;
            drp_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rr_q    <= rr_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            de_q    <= de_d;
            w_q     <= w_d;
            op_q    <= out_pulse;
            spk_q   <= spk_d;
            drp_q   <= drp_d;
        end
    end

    assign syn_gnt    = gnt;
    assign DE1        = de_q[0];
    assign DE2        = de_q[1];
    assign DE3        = de_q[2];
    assign W1         = w_q[0];
    assign W2         = w_q[1];
    assign W3         = w_q[2];
    assign busy       = (state_q != S_IDLE) || (cnt_q != '0);
    assign refractory = (state_q == S_REFR);
    assign spike_cnt  = spk_q;
    assign drop_cnt   = drp_q;

endmodule

// File: tb/tb_neuron_sched.sv
// Bench for neuron_sched: directed scenarios with a queue of expected
// dendrite indices that is drained as DE pulses appear.
module tb_neuron_sched;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [2:0] syn_req;
    logic [2:0] syn_gnt;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [3:0] cfg_wdata;
    logic       en;
    logic       out_pulse;
    logic       DE1, DE2, DE3;
    logic [3:0] W1, W2, W3;
    logic       busy, refractory;
    logic [7:0] spike_cnt, drop_cnt;
    logic [2:0] de;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    assign de = {DE3, DE2, DE1};

    always #5 Clk = ~Clk;

    neuron_sched dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .syn_req(syn_req), .syn_gnt(syn_gnt),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .en(en), .out_pulse(out_pulse),
        .DE1(DE1), .DE2(DE2), .DE3(DE3),
        .W1(W1), .W2(W2), .W3(W3),
        .busy(busy), .refractory(refractory),
        .spike_cnt(spike_cnt), .drop_cnt(drop_cnt)
    );

    task automatic test_reset;
        Rst_n = 1'b0;
        syn_req = 3'b111;
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if (syn_gnt !== 3'b000) begin
            failures++; $display("FAIL rst_gnt got=%b want=000", syn_gnt);
        end
        checks++;
        if (de !== 3'b000) begin
            failures++; $display("FAIL rst_de got=%b want=000", de);
        end
        checks++;
        if ({W3, W2, W1} !== 12'h000) begin
            failures++; $display("FAIL rst_w got=%h want=000", {W3, W2, W1});
        end
        checks++;
        if (busy !== 1'b0 || refractory !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags got=%b%b want=00", busy, refractory);
        end
        checks++;
        if (spike_cnt !== 8'd0 || drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_cnt got=%0d/%0d want=0/0", spike_cnt, drop_cnt);
        end
        syn_req = 3'b000;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_config;
        logic [1:0] sels [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [3:0] dats [4] = '{4'd5, 4'd9, 4'd15, 4'd7};
        logic [3:0] wexp [3] = '{4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            cfg_we = 1'b1; cfg_sel = sels[i]; cfg_wdata = dats[i];
            if (sels[i] != 2'd3) wexp[sels[i]] = dats[i];
            @(negedge Clk);
            cfg_we = 1'b0;
            checks++;
            if ({W3, W2, W1} !== {wexp[2], wexp[1], wexp[0]}) begin
                failures++;
                $display("FAIL cfg_w%0d got=%h want=%h", i, {W3, W2, W1},
                         {wexp[2], wexp[1], wexp[0]});
            end
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] gexp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        int eidx [4] = '{0, 1, 2, 0};
        int prev = -1;
        int e;
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (de !== 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rr_de got=%b want=none", de);
                end else begin
                    e = exp_q.pop_front();
                    if (de !== 3'(1 << e)) begin
                        failures++;
                        $display("FAIL rr_de got=%b want=%b", de, 3'(1 << e));
                    end
                end
                checks++;
                if (prev < 0 && c != 2) begin
                    failures++; $display("FAIL rr_latency got=%0d want=2", c);
                end else if (prev >= 0 && c - prev != 6) begin
                    failures++;
                    $display("FAIL rr_spacing got=%0d want=6", c - prev);
                end
                prev = c;
            end
            syn_req = (c < 4) ? 3'b111 : 3'b000;
            #1;
            if (c < 4) begin
                checks++;
                if (syn_gnt !== gexp[c]) begin
                    failures++;
                    $display("FAIL rr_gnt%0d got=%b want=%b", c, syn_gnt, gexp[c]);
                end
                exp_q.push_back(eidx[c]);
            end
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_drain got=%0d/%b want=0/0", exp_q.size(), busy);
        end
        exp_q.delete();
    endtask

    task automatic test_full;
        logic [2:0] gexp [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000};
        int eidx [4] = '{1, 2, 0, 1};
        int prev = -1;
        int e;
        en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            syn_req = 3'b111;
            #1;
            checks++;
            if (syn_gnt !== gexp[c]) begin
                failures++;
                $display("FAIL full_gnt%0d got=%b want=%b", c, syn_gnt, gexp[c]);
            end
            if (c < 4) exp_q.push_back(eidx[c]);
        end
        @(negedge Clk);
        checks++;
        if (busy !== 1'b1 || de !== 3'b000) begin
            failures++;
            $display("FAIL full_hold got=%b/%b want=1/000", busy, de);
        end
        en = 1'b1;
        #1;
        checks++;
        if (syn_gnt !== 3'b000) begin
            failures++; $display("FAIL full_pop_gnt got=%b want=000", syn_gnt);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            syn_req = 3'b000;
            if (de !== 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL full_de got=%b want=none", de);
                end else begin
                    e = exp_q.pop_front();
                    if (de !== 3'(1 << e)) begin
                        failures++;
                        $display("FAIL full_de got=%b want=%b", de, 3'(1 << e));
                    end
                end
                if (prev >= 0) begin
                    checks++;
                    if (c - prev != 6) begin
                        failures++;
                        $display("FAIL full_spacing got=%0d want=6", c - prev);
                    end
                end
                prev = c;
            end
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_drain got=%0d/%b want=0/0", exp_q.size(), busy);
        end
        exp_q.delete();
    endtask

    task automatic test_refractory;
        logic [2:0] gexp [3] = '{3'b100, 3'b001, 3'b010};
        int eidx [3] = '{2, 0, 1};
        int e;
        for (int c = 0; c < 31; c++) begin
            @(negedge Clk);
            if (de !== 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL refr_de c=%0d got=%b want=none", c, de);
                end else begin
                    e = exp_q.pop_front();
                    if (de !== 3'(1 << e)) begin
                        failures++;
                        $display("FAIL refr_de got=%b want=%b", de, 3'(1 << e));
                    end
                end
            end
            syn_req = (c < 3 || (c >= 7 && c <= 15)) ? 3'b111 : 3'b000;
            en = (c >= 3);
            out_pulse = (c == 6);
            if (c == 6) exp_q.delete();
            #1;
            if (c < 3) begin
                checks++;
                if (syn_gnt !== gexp[c]) begin
                    failures++;
                    $display("FAIL refr_gnt%0d got=%b want=%b", c, syn_gnt, gexp[c]);
                end
                exp_q.push_back(eidx[c]);
            end
            if (c >= 7 && c <= 14) begin
                checks++;
                if (refractory !== 1'b1 || syn_gnt !== 3'b000) begin
                    failures++;
                    $display("FAIL refr_win c=%0d got=%b/%b want=1/000",
                             c, refractory, syn_gnt);
                end
            end
            if (c == 8) begin
                checks++;
                if (spike_cnt !== 8'd1) begin
                    failures++; $display("FAIL refr_spike got=%0d want=1", spike_cnt);
                end
            end
            if (c == 15) begin
                checks++;
                if (refractory !== 1'b0 || syn_gnt !== 3'b100) begin
                    failures++;
                    $display("FAIL refr_exit got=%b/%b want=0/100", refractory, syn_gnt);
                end
                checks++;
                if (drop_cnt !== 8'd8) begin
                    failures++; $display("FAIL refr_drop got=%0d want=8", drop_cnt);
                end
                exp_q.push_back(2);
            end
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || drop_cnt !== 8'd8) begin
            failures++;
            $display("FAIL refr_end got=%0d/%b/%0d want=0/0/8",
                     exp_q.size(), busy, drop_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int n_de = 0;
        int e;
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (de !== 3'b000) begin
                n_de++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL mid_de got=%b want=none", de);
                end else begin
                    e = exp_q.pop_front();
                    if (de !== 3'(1 << e)) begin
                        failures++;
                        $display("FAIL mid_de got=%b want=%b", de, 3'(1 << e));
                    end
                end
            end
            syn_req = (c < 2) ? 3'b111 : 3'b000;
            en = (c >= 2);
            if (c < 2) exp_q.push_back(c);
        end
        checks++;
        if (n_de != 1) begin
            failures++; $display("FAIL mid_issue got=%0d want=1", n_de);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (de !== 3'b000 || busy !== 1'b0 || {W3, W2, W1} !== 12'h000) begin
            failures++;
            $display("FAIL mid_async got=%b/%b/%h want=000/0/000",
                     de, busy, {W3, W2, W1});
        end
        exp_q.delete();
        n_de = 0;
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (de !== 3'b000) n_de++;
        end
        checks++;
        if (n_de != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_stale got=%0d/%b want=0/0", n_de, busy);
        end
    endtask

    task automatic test_spike_sat;
        en = 1'b0;
        syn_req = 3'b000;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            out_pulse = 1'b1;
            @(negedge Clk);
            out_pulse = 1'b0;
            if (i == 99 || i == 254) begin
                checks++;
                if (spike_cnt !== 8'(i + 1)) begin
                    failures++;
                    $display("FAIL spike_%0d got=%0d want=%0d", i, spike_cnt, i + 1);
                end
            end
        end
        checks++;
        if (spike_cnt !== 8'd255) begin
            failures++; $display("FAIL spike_sat got=%0d want=255", spike_cnt);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++; $display("FAIL spike_drop got=%0d want=0", drop_cnt);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        syn_req = '0;
        cfg_we = 1'b0;
        cfg_sel = '0;
        cfg_wdata = '0;
        en = 1'b0;
        out_pulse = 1'b0;
        test_reset;
        test_config;
        test_round_robin;
        test_full;
        test_refractory;
        test_reset_mid;
        test_spike_sat;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_sched.md
# neuron_sched

Event scheduler and configuration controller for the three-synapse neuron datapath. It arbitrates round-robin between three synapse event requesters and queues accepted events in a 4-deep FIFO. It issues one single-cycle dendrite pulse (`DE1..DE3`) at a time and holds the per-synapse weights (`W1..W3`). It also enforces a refractory window after each output pulse from the inhibit stage.

## Interface
Parameters:
- `SETTLE_CYC`, default 4: cycles waited after each dendrite pulse before the next issue (≥1).
- `REFRACT_CYC`, default 8: refractory length in cycles after `out_pulse` (≥1).
- `FIFO_DEPTH`, fixed 4: event queue depth (power of two).

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Rst_n`, in, 1: asynchronous, active-low reset.
- `syn_req`, in, 3: level event requests, bit i = synapse i+1; held until granted.
- `syn_gnt`, out, 3: one-hot grant, combinational; a grant means the event is accepted this cycle.
- `cfg_we`, in, 1: weight write strobe.
- `cfg_sel`, in, 2: target weight, 0..2 → `W1..W3`; 3 ignored.
- `cfg_wdata`, in, 4: weight value.
- `en`, in, 1: enable from the inhibit stage; issue only while 1.
- `out_pulse`, in, 1: neuron output pulse.
- `DE1`, `DE2`, `DE3`, out, 1 each: dendrite event pulses, registered.
- `W1`, `W2`, `W3`, out, 4 each: registered weights.
- `busy`, out, 1: state ≠ IDLE or FIFO non-empty.
- `refractory`, out, 1: state = REFR.
- `spike_cnt`, out, 8: count of `out_pulse` rising cycles, saturating at 255.
- `drop_cnt`, out, 8: count of cycles with any request dropped in REFR, saturating at 255.

## Operation
- Reset values (async, while `Rst_n`=0): state IDLE, FIFO empty, RR pointer 0, `DE*`=0, `W*`=0, `syn_gnt`=0, `busy`=0, `refractory`=0, both counters 0.
- Arbiter: round-robin, starting from the RR pointer. It grants one requester per cycle only when the FIFO is not full and state ≠ REFR. On grant, the synapse index is pushed and the pointer moves to granted+1 mod 3.
- Full rule: a full FIFO gives no grant, even if a pop occurs in the same cycle.
- FSM:
  - IDLE → REFR if `out_pulse`=1.
  - Otherwise IDLE → ISSUE if the FIFO is non-empty and `en`=1; the FIFO is popped on this transition.
  - ISSUE lasts 1 cycle. The `DE` of the popped index is 1, all other `DE*` are 0. Next state is SETTLE, with the counter loaded to `SETTLE_CYC`-1.
  - SETTLE → REFR if `out_pulse`=1 (highest priority). Otherwise it decrements the counter and goes to IDLE when the counter reaches 0.
  - REFR: on entry the FIFO is flushed and the counter is loaded to `REFRACT_CYC`-1. The counter decrements to 0, then the state goes to IDLE. `out_pulse` during REFR does not restart the window.
- `out_pulse` in ISSUE is deferred: it is acted on in SETTLE if still high, else ignored.
- Config: `cfg_we`=1 with `cfg_sel`≤2 updates the selected weight on that edge. Writes are allowed in every state and are visible the next cycle.
- `spike_cnt` increments on a 0→1 edge of `out_pulse`. `drop_cnt` increments once per REFR cycle in which `syn_req`≠0.

## Timing
- Grant-to-DE latency with an empty FIFO, IDLE state and `en`=1: grant in cycle n, pop in n+1, `DE` high in n+2.
- Minimum spacing between consecutive `DE` pulses is `SETTLE_CYC`+2 cycles.
- When a push and a pop coincide on a non-full FIFO, both take effect. Occupancy is unchanged.
- Reset asserted mid-operation returns all outputs to their reset values immediately. Queued events are lost.

## Test plan
- Reset, write W1=5, W2=9, W3=15, then cfg_sel=3 with data 7 → `W1..W3` read 5/9/15 and are unchanged by the sel=3 write.
- `syn_req`=3'b111 held, `en`=1 → grants in order 001, 010, 100, 001 each accepted cycle; `DE1`, `DE2`, `DE3` pulses 6 cycles apart (SETTLE_CYC=4).
- `en`=0 with 5 requests → 4 grants, then `syn_gnt`=0 while full. Raising `en` drains the FIFO in FIFO order.
- `out_pulse` in SETTLE with 2 events queued → REFR for 8 cycles, FIFO empty, no grants, `drop_cnt`=8 with `syn_req` held, `spike_cnt`=1, then normal issue resumes.
- `Rst_n` dropped during ISSUE → `DE*`=0 asynchronously. After release, `busy`=0 and no stale events are issued.
- 300 `out_pulse` edges → `spike_cnt` saturates at 255.
